// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard unit:
//   - forwarding select encodings driven onto forwardAE / forwardBE
//   - multiplier tracker state encoding
//   - small helper functions for register-number comparisons
// Register $0 is hard-wired to zero, so it never counts as a dependency.
// -----------------------------------------------------------------------------
package hazard_pkg;

  // Execute-stage operand source selects
  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_W  = 2'b01;  // resultW from Writeback
  localparam logic [1:0] FWD_M  = 2'b10;  // ALUMultOutM from Memory

  // Multiplier tracker states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } multState_e;

  // True when a source register depends on a destination register.
  // $0 never creates a dependency.
  function automatic logic regMatch(input logic [4:0] srcReg,
                                    input logic [4:0] dstReg);
    return (srcReg != 5'd0) && (srcReg == dstReg);
  endfunction

  // Execute-stage forwarding select: the newer Memory result wins over
  // the older Writeback result.
  function automatic logic [1:0] fwdSelE(input logic [4:0] srcReg,
                                         input logic [4:0] dstRegM,
                                         input logic       regWriteM,
                                         input logic [4:0] dstRegW,
                                         input logic       regWriteW);
    logic [1:0] sel;
    if (regWriteM && regMatch(srcReg, dstRegM)) begin
      sel = FWD_M;
    end else if (regWriteW && regMatch(srcReg, dstRegW)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mult_tracker.sv
// -----------------------------------------------------------------------------
// mult_tracker
// Follows the multi-cycle multiplier so the hazard unit knows when HI/LO is
// still being produced. A watchdog returns the tracker to IDLE if the
// multiplier never reports completion, and latches a sticky flag.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   multStart    in   multiplier start pulse (Execute)
//   multDone     in   multiplier completion pulse (Execute)
//   multBusy     out  registered: tracker is in BUSY
//   multTimeout  out  registered, sticky: watchdog expired (cleared by rst)
// -----------------------------------------------------------------------------
module mult_tracker
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = 34
) (
  input  logic clk,
  input  logic rst,
  input  logic multStart,
  input  logic multDone,
  output logic multBusy,
  output logic multTimeout
);

  // Counter just wide enough to reach MULT_LAT-1; it never wraps because the
  // watchdog leaves BUSY on that terminal value.
  localparam int CW = (MULT_LAT > 2) ? $clog2(MULT_LAT) : 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MULT_LAT - 1);

  multState_e     state_r;
  logic [CW-1:0]  cnt_r;
  logic           multBusy_r;
  logic           multTimeout_r;

  // Tracker FSM with watchdog counter and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= CNT_ZERO;
      multBusy_r    <= 1'b0;
      multTimeout_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // A completion pulse with nothing outstanding is ignored.
          if (multStart) begin
            state_r    <= BUSY;
            cnt_r      <= CNT_ZERO;
            multBusy_r <= 1'b1;
          end else begin
            state_r    <= IDLE;
            cnt_r      <= cnt_r;
            multBusy_r <= 1'b0;
          end
        end
        BUSY: begin
          if (multStart) begin
            // A new multiply (even alongside a completion) restarts the window.
            state_r    <= BUSY;
            cnt_r      <= CNT_ZERO;
            multBusy_r <= 1'b1;
          end else if (multDone) begin
            state_r    <= IDLE;
            cnt_r      <= cnt_r;
            multBusy_r <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r       <= IDLE;
            cnt_r         <= cnt_r;
            multBusy_r    <= 1'b0;
            multTimeout_r <= 1'b1;
          end else begin
            state_r    <= BUSY;
            cnt_r      <= cnt_r + CNT_ONE;
            multBusy_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= CNT_ZERO;
          multBusy_r <= 1'b0;
        end
      endcase
    end
  end

  assign multBusy    = multBusy_r;
  assign multTimeout = multTimeout_r;

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Hazard detection and forwarding control for the five-stage MIPS pipeline.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rsD, rtD                     Decode source registers
//   rsE, rtE                     Execute source registers
//   WriteRegE/M, writeregW       destination registers in E, M, W
//   branchD                      branch resolving in Decode
//   hiloreadD                    Decode reads HI/LO or starts a multiply
//   MemtoRegE/M, RegWriteE/M/W   stage control bits
//   MultStartE, MultDoneE        multiplier start / completion pulses
//   stallF, stallD, flushE       combinational pipeline hold / bubble
//   forwardAD, forwardBD         combinational: 1 selects ALUMultOutM
//   forwardAE, forwardBE         combinational: 00 RF, 01 resultW, 10 ALUMultOutM
//   multbusy, multtimeout        registered multiplier status
//   stallcount                   registered saturating stall-cycle count
// -----------------------------------------------------------------------------
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = 34,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       writeregW,
  input  logic             branchD,
  input  logic             hiloreadD,
  input  logic             MemtoRegE,
  input  logic             RegWriteE,
  input  logic             MemtoRegM,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MultStartE,
  input  logic             MultDoneE,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             multbusy,
  output logic             multtimeout,
  output logic [CNT_W-1:0] stallcount
);

  localparam logic [CNT_W-1:0] SC_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] SC_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] SC_MAX  = {CNT_W{1'b1}};

  logic             lwStall_s;
  logic             branchStall_s;
  logic             multStall_s;
  logic             stall_s;
  logic [CNT_W-1:0] stallCount_r;

  mult_tracker #(
    .MULT_LAT (MULT_LAT)
  ) u_multTracker (
    .clk         (clk),
    .rst         (rst),
    .multStart   (MultStartE),
    .multDone    (MultDoneE),
    .multBusy    (multbusy),
    .multTimeout (multtimeout)
  );

  // Operand forwarding selects for Execute and for the Decode branch compare
  always_comb begin
    forwardAE = fwdSelE(rsE, WriteRegM, RegWriteM, writeregW, RegWriteW);
    forwardBE = fwdSelE(rtE, WriteRegM, RegWriteM, writeregW, RegWriteW);
    forwardAD = RegWriteM & regMatch(rsD, WriteRegM);
    forwardBD = RegWriteM & regMatch(rtD, WriteRegM);
  end

  // Stall detection: load-use, branch operand not yet available, HI/LO pending
  always_comb begin
    lwStall_s = MemtoRegE & regMatch(rtE, rsD) | MemtoRegE & regMatch(rtE, rtD);

    // A branch compares in Decode, so an ALU result still in E, or a load
    // result still in M, cannot be forwarded in time.
    branchStall_s = branchD &
                    ((RegWriteE & (regMatch(WriteRegE, rsD) | regMatch(WriteRegE, rtD))) |
                     (MemtoRegM & (regMatch(WriteRegM, rsD) | regMatch(WriteRegM, rtD))));

    // The completion pulse releases the stall in the same cycle; a start
    // pulse stalls immediately, before the tracker has registered BUSY.
    multStall_s = hiloreadD & ((multbusy & ~MultDoneE) | MultStartE);

    stall_s = lwStall_s | branchStall_s | multStall_s;
    stallF  = stall_s;
    stallD  = stall_s;
    flushE  = stall_s;
  end

  // Saturating count of cycles spent stalled in Decode
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount_r <= SC_ZERO;
    end else if (stall_s && (stallCount_r != SC_MAX)) begin
      stallCount_r <= stallCount_r + SC_ONE;
    end else begin
      stallCount_r <= stallCount_r;
    end
  end

  assign stallcount = stallCount_r;

endmodule
